imem_port_arbiter: RTL and testbench

//  Shares one 128-bit instruction-memory read port between the fetch window (high-line

---
 rtl/imem_port_arbiter_pkg.sv | 23 ++
 rtl/imem_response_tracker.sv | 42 ++++
 rtl/imem_port_arbiter.sv | 80 ++++++++
 tb/tb_imem_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_port_arbiter_pkg.sv
// imem_port_arbiter_pkg: shared types, defaults and tag helper for the instruction-memory port arbiter.
package imem_port_arbiter_pkg;

    localparam int IMEM_MEM_LATENCY  = 1;
    localparam int IMEM_STARVE_LIMIT = 4;
    localparam int IMEM_STARVE_W     = 4;

    typedef enum logic {OWNER_FETCH = 1'b0, OWNER_AUX = 1'b1} imemOwner_t;

    typedef struct packed {
        logic       valid;
        imemOwner_t owner;
    } imemTag_t;

    // A redirect kills fetch traffic only; aux lines always survive.
    function automatic imemTag_t imem_squash(input imemTag_t tag, input logic redirect);
        imemTag_t t;
        t = tag;
        if (redirect && tag.owner == OWNER_FETCH) t.valid = 1'b0;
        return t;
    endfunction

endpackage

// File: rtl/imem_response_tracker.sv
// imem_response_tracker: owner-tag shift register that steers returning memory lines
// to fetch or aux and squashes in-flight fetch lines on redirect.
module imem_response_tracker
    import imem_port_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY = IMEM_MEM_LATENCY
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         redirect_i,
    input  logic         issue_i,
    input  logic         owner_aux_i,
    input  logic [127:0] mem_read_data_i,
    output logic         fetch_resp_valid_o,
    output logic [127:0] fetch_resp_data_o,
    output logic         aux_resp_valid_o,
    output logic [127:0] aux_resp_data_o
);

    imemTag_t [MEM_LATENCY-1:0] tag_q;
    imemTag_t [MEM_LATENCY-1:0] tag_d;
    imemTag_t                   exit_tag;

    always_comb begin
        tag_d    = tag_q;
        tag_d[0] = '{valid: issue_i, owner: owner_aux_i ? OWNER_AUX : OWNER_FETCH};
        for (int i = 1; i < MEM_LATENCY; i++) tag_d[i] = imem_squash(tag_q[i-1], redirect_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) tag_q <= '0;
        else         tag_q <= tag_d;
    end

    // The slot leaving the pipe this cycle is squashed too, so a redirect never sees a fetch response.
    assign exit_tag           = imem_squash(tag_q[MEM_LATENCY-1], redirect_i);
    assign fetch_resp_valid_o = exit_tag.valid && exit_tag.owner == OWNER_FETCH;
    assign aux_resp_valid_o   = exit_tag.valid && exit_tag.owner == OWNER_AUX;
    assign fetch_resp_data_o  = mem_read_data_i;
    assign aux_resp_data_o    = mem_read_data_i;

endmodule

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one 128-bit instruction-memory read port between fetch
// (priority) and an aux reader whose wait is bounded by a starvation counter.
module imem_port_arbiter
    import imem_port_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY  = IMEM_MEM_LATENCY,
    parameter int STARVE_LIMIT = IMEM_STARVE_LIMIT
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         redirect_i,
    input  logic         fetch_req_valid_i,
    input  logic [31:0]  fetch_req_address_i,
    output logic         fetch_req_ready_o,
    output logic         fetch_resp_valid_o,
    output logic [127:0] fetch_resp_data_o,
    input  logic         aux_req_valid_i,
    input  logic [31:0]  aux_req_address_i,
    output logic         aux_req_ready_o,
    output logic         aux_resp_valid_o,
    output logic [127:0] aux_resp_data_o,
    output logic         mem_read_enable_o,
    output logic [31:0]  mem_read_address_o,
    input  logic [127:0] mem_read_data_i
);

    localparam logic [IMEM_STARVE_W-1:0] LIMIT = IMEM_STARVE_W'(STARVE_LIMIT);

    logic                     active_q;
    logic [IMEM_STARVE_W-1:0] starve_q;
    logic [IMEM_STARVE_W-1:0] starve_d;
    logic                     fetch_eligible;
    logic                     aux_forced;
    logic                     grant_fetch;
    logic                     grant_aux;
    logic                     issue;

    // active_q holds every grant off until the first edge after reset is released.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            starve_q <= '0;
        end else begin
            active_q <= 1'b1;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        fetch_eligible = fetch_req_valid_i & ~redirect_i;
        aux_forced     = aux_req_valid_i & (starve_q == LIMIT);
        grant_fetch    = active_q & fetch_eligible & ~aux_forced;
        grant_aux      = active_q & aux_req_valid_i & (aux_forced | ~fetch_eligible);
        issue          = grant_fetch | grant_aux;
        starve_d       = (!aux_req_valid_i || grant_aux) ? '0 :
                         (starve_q == LIMIT) ? starve_q : starve_q + 1'b1;
    end

    assign fetch_req_ready_o  = grant_fetch;
    assign aux_req_ready_o    = grant_aux;
    assign mem_read_enable_o  = issue;
    assign mem_read_address_o = !issue ? '0 :
                                (grant_aux ? aux_req_address_i : fetch_req_address_i) & ~32'hF;

    imem_response_tracker #(
        .MEM_LATENCY(MEM_LATENCY)
    ) u_tracker (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .redirect_i         (redirect_i),
        .issue_i            (issue),
        .owner_aux_i        (grant_aux),
        .mem_read_data_i    (mem_read_data_i),
        .fetch_resp_valid_o (fetch_resp_valid_o),
        .fetch_resp_data_o  (fetch_resp_data_o),
        .aux_resp_valid_o   (aux_resp_valid_o),
        .aux_resp_data_o    (aux_resp_data_o)
    );

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: directed bench driving a latency-1 and a latency-2 arbiter
// from shared inputs, each with its own memory model.
module tb_imem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd = 1'b0;
    logic        fv = 1'b0;
    logic        av = 1'b0;
    logic [31:0] fa = '0;
    logic [31:0] aa = '0;

    logic         a_fr, a_frv, a_ar, a_arv, a_en;
    logic         b_fr, b_frv, b_ar, b_arv, b_en;
    logic [31:0]  a_addr, b_addr;
    logic [127:0] a_fdata, a_adata, b_fdata, b_adata;
    logic [127:0] a_mem, b_mem1, b_mem2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [127:0] mem_line(input logic [31:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h0123_4567};
    endfunction

    always @(posedge clk) begin
        a_mem  <= mem_line(a_addr);
        b_mem1 <= mem_line(b_addr);
        b_mem2 <= b_mem1;
    end

    imem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .redirect_i(rd),
        .fetch_req_valid_i(fv), .fetch_req_address_i(fa), .fetch_req_ready_o(a_fr),
        .fetch_resp_valid_o(a_frv), .fetch_resp_data_o(a_fdata),
        .aux_req_valid_i(av), .aux_req_address_i(aa), .aux_req_ready_o(a_ar),
        .aux_resp_valid_o(a_arv), .aux_resp_data_o(a_adata),
        .mem_read_enable_o(a_en), .mem_read_address_o(a_addr), .mem_read_data_i(a_mem)
    );

    imem_port_arbiter #(.MEM_LATENCY(2), .STARVE_LIMIT(4)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .redirect_i(rd),
        .fetch_req_valid_i(fv), .fetch_req_address_i(fa), .fetch_req_ready_o(b_fr),
        .fetch_resp_valid_o(b_frv), .fetch_resp_data_o(b_fdata),
        .aux_req_valid_i(av), .aux_req_address_i(aa), .aux_req_ready_o(b_ar),
        .aux_resp_valid_o(b_arv), .aux_resp_data_o(b_adata),
        .mem_read_enable_o(b_en), .mem_read_address_o(b_addr), .mem_read_data_i(b_mem2)
    );

    task automatic step(input logic f, input logic [31:0] fad, input logic a,
                        input logic [31:0] aad, input logic r);
        @(negedge clk);
        fv = f; fa = fad; av = a; aa = aad; rd = r;
        #1;
    endtask

    task automatic test_reset;
        fv = 1'b1; fa = 32'h44;
        #2;
        checks++;
        if ({a_fr, a_ar, a_en, a_frv, a_arv, b_fr, b_ar, b_en, b_frv, b_arv} !== 10'b0 ||
            a_addr !== 32'h0 || b_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got ctl=%b%b%b%b%b/%b%b%b%b%b addr=%h/%h exp all 0",
                     a_fr, a_ar, a_en, a_frv, a_arv, b_fr, b_ar, b_en, b_frv, b_arv, a_addr, b_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({a_fr, a_en, b_fr, b_en} !== 4'b0 || a_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_release_gate got fr=%b en=%b addr=%h exp 0 0 0", a_fr, a_en, a_addr);
        end
        step(0, 0, 0, 0, 0);
        checks++;
        if ({a_frv, a_arv, b_frv, b_arv} !== 4'b0) begin
            errors++;
            $display("FAIL reset_idle_valid got %b%b%b%b exp 0000", a_frv, a_arv, b_frv, b_arv);
        end
    endtask

    task automatic test_fetch_only;
        step(1, 32'h44, 0, 0, 0);
        checks++;
        if ({a_fr, a_ar, a_en} !== 3'b101 || a_addr !== 32'h40 || b_addr !== 32'h40) begin
            errors++;
            $display("FAIL fetch_issue got fr/ar/en=%b%b%b addr=%h/%h exp 101 00000040",
                     a_fr, a_ar, a_en, a_addr, b_addr);
        end
        step(0, 0, 0, 0, 0);
        checks++;
        if (a_frv !== 1'b1 || a_arv !== 1'b0 || a_fdata !== mem_line(32'h40) || b_frv !== 1'b0) begin
            errors++;
            $display("FAIL fetch_resp_lat1 got v=%b av=%b bv=%b data=%h exp 1 0 0 %h",
                     a_frv, a_arv, b_frv, a_fdata, mem_line(32'h40));
        end
        step(0, 0, 0, 0, 0);
        checks++;
        if (b_frv !== 1'b1 || b_arv !== 1'b0 || b_fdata !== mem_line(32'h40) || a_frv !== 1'b0) begin
            errors++;
            $display("FAIL fetch_resp_lat2 got v=%b av=%b a_v=%b data=%h exp 1 0 0 %h",
                     b_frv, b_arv, a_frv, b_fdata, mem_line(32'h40));
        end
        step(0, 0, 0, 0, 0);
        checks++;
        if ({a_frv, a_arv, b_frv, b_arv} !== 4'b0) begin
            errors++;
            $display("FAIL fetch_drain got %b%b%b%b exp 0000", a_frv, a_arv, b_frv, b_arv);
        end
    endtask

    task automatic test_starve;
        logic        exp_aux;
        logic        prev_aux = 1'b0;
        logic [31:0] exp_addr;
        for (int i = 0; i < 10; i++) begin
            step(1, 32'h100 + 32'(i * 16), 1, 32'h808, 0);
            exp_aux  = (i % 5 == 4);
            exp_addr = exp_aux ? 32'h800 : 32'h100 + 32'(i * 16);
            checks++;
            if ({a_fr, a_ar} !== {~exp_aux, exp_aux} || {b_fr, b_ar} !== {~exp_aux, exp_aux} ||
                a_addr !== exp_addr) begin
                errors++;
                $display("FAIL starve_grant[%0d] got a=%b%b b=%b%b addr=%h exp %b%b %h",
                         i, a_fr, a_ar, b_fr, b_ar, a_addr, ~exp_aux, exp_aux, exp_addr);
            end
            if (i > 0) begin
                checks++;
                if ({a_frv, a_arv} !== {~prev_aux, prev_aux}) begin
                    errors++;
                    $display("FAIL starve_resp[%0d] got %b%b exp %b%b", i, a_frv, a_arv, ~prev_aux, prev_aux);
                end
            end
            prev_aux = exp_aux;
        end
        step(0, 0, 0, 0, 0);
        checks++;
        if ({a_frv, a_arv} !== 2'b01 || a_adata !== mem_line(32'h800)) begin
            errors++;
            $display("FAIL starve_last_resp got %b%b data=%h exp 01 %h", a_frv, a_arv, a_adata, mem_line(32'h800));
        end
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_redirect;
        step(1, 32'h200, 0, 0, 0);
        checks++;
        if (b_fr !== 1'b1 || b_addr !== 32'h200) begin
            errors++;
            $display("FAIL redir_pre_issue got fr=%b addr=%h exp 1 00000200", b_fr, b_addr);
        end
        step(1, 32'h200, 1, 32'h308, 1);
        checks++;
        if ({b_fr, b_ar} !== 2'b01 || b_addr !== 32'h300 || a_frv !== 1'b0) begin
            errors++;
            $display("FAIL redir_aux_issue got b=%b%b addr=%h a_frv=%b exp 01 00000300 0",
                     b_fr, b_ar, b_addr, a_frv);
        end
        step(0, 0, 0, 0, 0);
        checks++;
        if ({b_frv, b_arv} !== 2'b00 || a_arv !== 1'b1 || a_adata !== mem_line(32'h300)) begin
            errors++;
            $display("FAIL redir_squash got b=%b%b a_arv=%b data=%h exp 00 1 %h",
                     b_frv, b_arv, a_arv, a_adata, mem_line(32'h300));
        end
        step(0, 0, 0, 0, 0);
        checks++;
        if ({b_frv, b_arv} !== 2'b01 || b_adata !== mem_line(32'h300)) begin
            errors++;
            $display("FAIL redir_aux_resp got %b%b data=%h exp 01 %h", b_frv, b_arv, b_adata, mem_line(32'h300));
        end
        for (int i = 0; i < 4; i++) step(1, 32'h400 + 32'(i * 16), 1, 32'h900, 0);
        step(1, 32'h440, 1, 32'h900, 1);
        checks++;
        if ({b_fr, b_ar, a_fr, a_ar} !== 4'b0101 || b_frv !== 1'b0 || a_frv !== 1'b0 || b_addr !== 32'h900) begin
            errors++;
            $display("FAIL redir_forced got b=%b%b a=%b%b frv=%b/%b addr=%h exp 0101 0/0 00000900",
                     b_fr, b_ar, a_fr, a_ar, a_frv, b_frv, b_addr);
        end
        step(0, 0, 0, 0, 0);
        checks++;
        if ({b_frv, b_arv, a_frv, a_arv} !== 4'b0001) begin
            errors++;
            $display("FAIL redir_forced_next got b=%b%b a=%b%b exp 0001", b_frv, b_arv, a_frv, a_arv);
        end
        step(0, 0, 0, 0, 0);
        checks++;
        if ({b_frv, b_arv} !== 2'b01 || b_adata !== mem_line(32'h900)) begin
            errors++;
            $display("FAIL redir_forced_resp got %b%b data=%h exp 01 %h", b_frv, b_arv, b_adata, mem_line(32'h900));
        end
    endtask

    task automatic test_alternate;
        logic        f, prev_f = 1'b0;
        logic [31:0] addr, prev_addr = '0;
        for (int i = 0; i <= 16; i++) begin
            f    = (i % 2 == 0);
            addr = f ? 32'h1000 + 32'(i * 16) : 32'h2000 + 32'(i * 16);
            if (i < 16) step(f, addr, ~f, addr, 0);
            else        step(0, 0, 0, 0, 0);
            if (i < 16) begin
                checks++;
                if ({a_fr, a_ar} !== {f, ~f} || a_addr !== addr) begin
                    errors++;
                    $display("FAIL alt_grant[%0d] got %b%b addr=%h exp %b%b %h", i, a_fr, a_ar, a_addr, f, ~f, addr);
                end
            end
            if (i > 0) begin
                checks++;
                if ({a_frv, a_arv} !== {prev_f, ~prev_f} ||
                    (prev_f ? a_fdata : a_adata) !== mem_line(prev_addr)) begin
                    errors++;
                    $display("FAIL alt_resp[%0d] got %b%b data=%h exp %b%b %h", i, a_frv, a_arv,
                             prev_f ? a_fdata : a_adata, prev_f, ~prev_f, mem_line(prev_addr));
                end
            end
            prev_f    = f;
            prev_addr = addr;
        end
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_midflight;
        step(1, 32'h500, 0, 0, 0);
        step(0, 0, 1, 32'h600, 0);
        @(negedge clk);
        fv = 1'b1; fa = 32'h44; av = 1'b0; rst_n = 1'b0;
        #1;
        checks++;
        if ({a_fr, a_ar, a_en, a_frv, a_arv, b_fr, b_ar, b_en, b_frv, b_arv} !== 10'b0 ||
            a_addr !== 32'h0 || b_addr !== 32'h0) begin
            errors++;
            $display("FAIL midflight_reset got a=%b%b%b%b%b b=%b%b%b%b%b exp all 0",
                     a_fr, a_ar, a_en, a_frv, a_arv, b_fr, b_ar, b_en, b_frv, b_arv);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({a_fr, a_en, a_frv, a_arv, b_fr, b_en, b_frv, b_arv} !== 8'b0) begin
            errors++;
            $display("FAIL midflight_release got a=%b%b%b%b b=%b%b%b%b exp 0",
                     a_fr, a_en, a_frv, a_arv, b_fr, b_en, b_frv, b_arv);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            checks++;
            if ({a_frv, a_arv, b_frv, b_arv} !== 4'b0) begin
                errors++;
                $display("FAIL midflight_late[%0d] got %b%b%b%b exp 0000", i, a_frv, a_arv, b_frv, b_arv);
            end
        end
        test_fetch_only();
    endtask

    task automatic test_redirect_block;
        step(1, 32'h700, 0, 0, 1);
        checks++;
        if ({a_fr, a_en, b_fr, b_en} !== 4'b0 || a_addr !== 32'h0) begin
            errors++;
            $display("FAIL redirect_block got a=%b%b b=%b%b addr=%h exp 0000 0", a_fr, a_en, b_fr, b_en, a_addr);
        end
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        checks++;
        if ({a_frv, b_frv} !== 2'b0) begin
            errors++;
            $display("FAIL redirect_block_resp got %b%b exp 00", a_frv, b_frv);
        end
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_starve();
        test_redirect();
        test_alternate();
        test_reset_midflight();
        test_redirect_block();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
